// File: rtl/memout_reader_pkg.sv
// Shared types and constants for the output-memory page reader.
package memout_reader_pkg;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} stateT;

  localparam int FIFO_DEPTH = 4;

  function automatic int pageDepth(input int addrW, input int pageBits);
    return 1 << (addrW - pageBits);
  endfunction

endpackage

// File: rtl/memout_reader_fifo.sv
// Small 4-entry FIFO carrying a data word plus its end-of-page flag.
module memout_reader_fifo
  import memout_reader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [DATA_W-1:0]             pushData,
  input  logic                          pushLast,
  input  logic                          pop,
  output logic [DATA_W-1:0]             popData,
  output logic                          popLast,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wrPtr, rdPtr;
  logic [CNT_W-1:0]   countReg;
  logic               doPush, doPop;
  logic [DATA_W:0]    head;

  assign doPush = push && (countReg != CNT_W'(FIFO_DEPTH));
  assign doPop  = pop && (countReg != '0);

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= {pushLast, pushData};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      countReg <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   countReg <= countReg + 1'b1;
        2'b01:   countReg <= countReg - 1'b1;
        default: countReg <= countReg;
      endcase
    end
  end

  // Outputs read as zero when empty so stale entries never leak out.
  assign head    = mem[rdPtr];
  assign empty   = (countReg == '0);
  assign popData = empty ? '0 : head[DATA_W-1:0];
  assign popLast = ~empty & head[DATA_W];
  assign count   = countReg;

endmodule

// File: rtl/memout_reader.sv
// Drains one BX page of the output BRAM (port B) and streams it on valid/ready.
module memout_reader
  import memout_reader_pkg::*;
#(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int PAGE_BITS = 1,
  parameter int RD_LAT    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              bx_in,
  input  logic [ADDR_W-PAGE_BITS:0] nent,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun,
  output logic                    mem_enb,
  output logic [ADDR_W-1:0]       mem_readaddr,
  input  logic [DATA_W-1:0]       mem_dout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  output logic [1:0]              out_bx
);

  localparam int IDX_W = ADDR_W - PAGE_BITS;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W:0] PAGE_CNT = (IDX_W+1)'(pageDepth(ADDR_W, PAGE_BITS));
  localparam logic [CNT_W:0] OCC_MAX  = (CNT_W+1)'(FIFO_DEPTH);

  stateT              stateReg, stateNext;
  logic [1:0]         bxReg, bxNext;
  logic [IDX_W:0]     cntReg, cntNext, idxReg, idxNext, nentClamped;
  logic [ADDR_W-1:0]  addrReg, addrCur;
  logic               overrunReg;
  logic [CNT_W-1:0]   inflightReg, fifoCount;
  logic [CNT_W:0]     occupancy;
  logic               issue, issueLast, push, pushLast, pop, fifoEmpty, drainDone;
  logic [RD_LAT-1:0]  vldPipe, lastPipe;

  assign nentClamped = (nent > PAGE_CNT) ? PAGE_CNT : nent;
  // Buffered plus in-flight words never exceed the FIFO, so a push always fits.
  assign occupancy   = {1'b0, fifoCount} + {1'b0, inflightReg};
  assign issue       = (stateReg == READ) && (idxReg < cntReg) && (occupancy < OCC_MAX);
  assign issueLast   = (idxReg + 1'b1) == cntReg;
  assign addrCur     = {bxReg[PAGE_BITS-1:0], idxReg[IDX_W-1:0]};
  assign pop         = out_valid & out_ready;
  // Leave DRAIN on the cycle the final word is accepted, not one later.
  assign drainDone   = (inflightReg == '0) &&
                       ((fifoCount == '0) || ((fifoCount == CNT_W'(1)) && pop));

  always_comb begin
    stateNext = stateReg;
    bxNext    = bxReg;
    cntNext   = cntReg;
    idxNext   = idxReg;
    case (stateReg)
      IDLE: begin
        if (start) begin
          bxNext    = bx_in;
          cntNext   = nentClamped;
          idxNext   = '0;
          stateNext = (nentClamped == '0) ? FIN : READ;
        end
      end
      READ: begin
        if (issue) begin
          idxNext = idxReg + 1'b1;
          if (issueLast) stateNext = DRAIN;
        end
      end
      DRAIN: begin
        if (drainDone) stateNext = FIN;
      end
      FIN: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg    <= IDLE;
      bxReg       <= '0;
      cntReg      <= '0;
      idxReg      <= '0;
      addrReg     <= '0;
      overrunReg  <= 1'b0;
      inflightReg <= '0;
    end else begin
      stateReg    <= stateNext;
      bxReg       <= bxNext;
      cntReg      <= cntNext;
      idxReg      <= idxNext;
      if (issue) addrReg <= addrCur;
      if (start && (stateReg != IDLE)) overrunReg <= 1'b1;
      inflightReg <= inflightReg + CNT_W'(issue) - CNT_W'(push);
    end
  end

  // Valid/last tags travel alongside the BRAM read pipeline.
  for (genvar gi = 0; gi < RD_LAT; gi++) begin : gLat
    if (gi == 0) begin : gHead
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          vldPipe[0]  <= 1'b0;
          lastPipe[0] <= 1'b0;
        end else begin
          vldPipe[0]  <= issue;
          lastPipe[0] <= issue & issueLast;
        end
      end
    end else begin : gTail
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          vldPipe[gi]  <= 1'b0;
          lastPipe[gi] <= 1'b0;
        end else begin
          vldPipe[gi]  <= vldPipe[gi-1];
          lastPipe[gi] <= lastPipe[gi-1];
        end
      end
    end
  end

  assign push     = vldPipe[RD_LAT-1];
  assign pushLast = lastPipe[RD_LAT-1];

  memout_reader_fifo #(
    .DATA_W (DATA_W)
  ) uFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pushData (mem_dout),
    .pushLast (pushLast),
    .pop      (pop),
    .popData  (out_data),
    .popLast  (out_last),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  assign busy         = (stateReg == READ) || (stateReg == DRAIN);
  assign done         = (stateReg == FIN);
  assign overrun      = overrunReg;
  assign mem_enb      = issue;
  assign mem_readaddr = issue ? addrCur : addrReg;
  assign out_valid    = ~fifoEmpty;
  assign out_bx       = bxReg;

endmodule

// File: tb/tb_memout_reader.sv
// Table-driven bench for memout_reader with a BRAM model whose words equal their address.
module tb_memout_reader;

  localparam int ADDR_W = 5, DATA_W = 32, PAGE_BITS = 1, RD_LAT = 1;

  logic              clk, reset, start, busy, done, overrun, mem_enb;
  logic [1:0]        bx_in, out_bx;
  logic [4:0]        nent;
  logic [4:0]        mem_readaddr;
  logic [31:0]       mem_dout, out_data;
  logic              out_valid, out_ready, out_last;

  memout_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PAGE_BITS(PAGE_BITS), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .bx_in(bx_in), .nent(nent),
    .busy(busy), .done(done), .overrun(overrun), .mem_enb(mem_enb),
    .mem_readaddr(mem_readaddr), .mem_dout(mem_dout), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .out_bx(out_bx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-cycle-latency BRAM: word content equals its address.
  always @(posedge clk) if (mem_enb) mem_dout <= {27'b0, mem_readaddr};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [1:0]  bx;
    int          c;
  } hs_t;

  typedef struct {
    logic [1:0] bx;
    logic [4:0] nent;
    int         stall;
    int         dup;
    int         expReads;
    int         expFirst;
    int         expOverrun;
  } vec_t;

  hs_t  hsQ[$];
  hs_t  expQ[$];
  int   rdAddrQ[$], rdCycQ[$], doneQ[$], validRiseQ[$];
  int   readsTot = 0, takenTot = 0, maxOut = 0, stabBad = 0, busyAtDoneBad = 0;
  bit   newPage = 0;
  int   checks = 0, errors = 0;
  vec_t vecs[7];

  // Monitor: logs DUT events only; all judgements are made by the main sequence.
  initial begin : monitor
    logic        prevStall, prevLast, prevValid;
    logic [31:0] prevData;
    prevStall = 0; prevLast = 0; prevValid = 0; prevData = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        takenTot  = readsTot;
        prevStall = 0;
        prevValid = 0;
      end else begin
        if (start && newPage) maxOut = 0;
        if (mem_enb) begin
          readsTot++;
          rdAddrQ.push_back(int'(mem_readaddr));
          rdCycQ.push_back(cyc);
        end
        if (readsTot - takenTot > maxOut) maxOut = readsTot - takenTot;
        if (out_valid && !prevValid) validRiseQ.push_back(cyc);
        if (prevStall && (!out_valid || out_data !== prevData || out_last !== prevLast)) stabBad++;
        if (out_valid && out_ready) begin
          hsQ.push_back('{out_data, out_last, out_bx, cyc});
          takenTot++;
        end
        if (done) begin
          doneQ.push_back(cyc);
          if (busy) busyAtDoneBad++;
        end
        prevStall = out_valid && !out_ready;
        prevData  = out_data;
        prevLast  = out_last;
        prevValid = out_valid;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
    check({tag, "_mem_enb"}, int'(mem_enb), 0);
    check({tag, "_readaddr"}, int'(mem_readaddr), 0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_last"}, int'(out_last), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
    check({tag, "_out_bx"}, int'(out_bx), 0);
  endtask

  task automatic pushExpected(input logic [1:0] bx, input int m);
    for (int i = 0; i < m; i++)
      expQ.push_back('{32'((bx[0] ? 16 : 0) + i), (i == m - 1), bx, 0});
  endtask

  task automatic compareWords(input int hb, input int n);
    hs_t e;
    for (int i = 0; i < n; i++) begin
      if (expQ.size() == 0) begin
        check("sb_unexpected_word", int'(hsQ[hb+i].data), -1);
      end else begin
        e = expQ.pop_front();
        check("sb_data", int'(hsQ[hb+i].data), int'(e.data));
        check("sb_last", int'(hsQ[hb+i].last), int'(e.last));
        check("sb_bx", int'(hsQ[hb+i].bx), int'(e.bx));
      end
    end
  endtask

  task automatic runVec(input int id, input vec_t v);
    int rb, hb, db, vb, sb, m, k, s, nr, nw;
    rb = rdAddrQ.size(); hb = hsQ.size(); db = doneQ.size();
    vb = validRiseQ.size(); sb = stabBad;
    m  = (v.nent > 5'd16) ? 16 : int'(v.nent);
    pushExpected(v.bx, m);
    out_ready = (v.stall == 0);
    newPage = 1; start = 1; bx_in = v.bx; nent = v.nent; s = cyc;
    tick();
    start = 0; newPage = 0;
    if (v.dup > 0) begin
      repeat (v.dup - 1) tick();
      start = 1; bx_in = 2'd2; nent = 5'd3;
      tick();
      start = 0;
    end
    if (v.stall > 0) begin
      k = 0;
      while (!out_valid && k < 20) begin tick(); k++; end
      repeat (v.stall) tick();
      out_ready = 1;
    end
    k = 0;
    while (doneQ.size() == db && k < 300) begin tick(); k++; end
    tick(); tick();

    nr = rdAddrQ.size() - rb;
    nw = hsQ.size() - hb;
    check("reads", nr, v.expReads);
    for (int i = 0; i < nr && i < v.expReads; i++) check("rd_addr", rdAddrQ[rb+i], v.expFirst + i);
    if (v.expReads > 0 && nr > 0) check("enb_latency", rdCycQ[rb] - s, 1);
    if (m > 0) begin
      if (validRiseQ.size() > vb) check("valid_latency", validRiseQ[vb] - s, 2 + RD_LAT);
      else check("valid_latency", -1, 2 + RD_LAT);
    end
    check("words", nw, m);
    compareWords(hb, nw);
    check("sb_leftover", expQ.size(), 0);
    expQ.delete();
    check("done_count", doneQ.size() - db, 1);
    if (doneQ.size() > db) begin
      if (m > 0 && nw > 0) check("done_after_last", doneQ[db] - hsQ[hsQ.size()-1].c, 1);
      if (m == 0) check("zero_done_latency", int'((doneQ[db] - s) >= 1 && (doneQ[db] - s) <= 2), 1);
    end
    check("busy_at_done", busyAtDoneBad, 0);
    check("busy_after", int'(busy), 0);
    check("stable_under_stall", stabBad - sb, 0);
    if (v.stall > 0) check("max_outstanding", maxOut, 4);
    else check("outstanding_bound", int'(maxOut <= 4), 1);
    check("overrun", int'(overrun), v.expOverrun);
    $display("vec %0d bx=%0d nent=%0d stall=%0d reads=%0d words=%0d checks=%0d errors=%0d",
             id, v.bx, v.nent, v.stall, nr, nw, checks, errors);
  endtask

  initial begin : main
    int hb, db, k;
    reset = 1; start = 0; bx_in = 0; nent = 0; out_ready = 1;
    #2 reset = 0;
    repeat (3) tick();
    checkIdle("por");
    reset = 1;
    tick();

    //            bx    nent  stall dup reads first ovr
    vecs[0] = '{2'd1, 5'd5,  0,  0,  5,  16, 0};
    vecs[1] = '{2'd0, 5'd16, 10, 0,  16, 0,  0};
    vecs[2] = '{2'd0, 5'd0,  0,  0,  0,  0,  0};
    vecs[3] = '{2'd3, 5'd20, 0,  0,  16, 16, 0};
    vecs[4] = '{2'd2, 5'd3,  0,  0,  3,  0,  0};
    vecs[5] = '{2'd1, 5'd8,  0,  3,  8,  16, 1};
    vecs[6] = '{2'd0, 5'd2,  0,  0,  2,  0,  1};
    for (int i = 0; i < 7; i++) runVec(i, vecs[i]);

    // Reset mid-page: partial delivery, then no done and no stale words afterwards.
    hb = hsQ.size(); db = doneQ.size();
    pushExpected(2'd1, 8);
    newPage = 1; start = 1; bx_in = 2'd1; nent = 5'd8;
    tick();
    start = 0; newPage = 0;
    k = 0;
    while (hsQ.size() - hb < 3 && k < 50) begin tick(); k++; end
    reset = 0;
    #1;
    checkIdle("midreset");
    compareWords(hb, hsQ.size() - hb);
    expQ.delete();
    repeat (3) tick();
    check("abort_no_done", doneQ.size() - db, 0);
    reset = 1;
    tick();
    runVec(7, '{2'd0, 5'd2, 0, 0, 2, 0, 0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
